// File: rtl/datapath_seq.sv
// Bus-based ALU datapath: register file plus Y/Z/HI registers, sequenced through three
// micro-steps per instruction (operand A to Y, ALU into Z, Z low half written back).
module datapath_seq #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 16,
  localparam int unsigned REG_AW  = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [REG_AW-1:0] ra,
  input  logic [REG_AW-1:0] rb,
  input  logic [REG_AW-1:0] rd,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [REG_AW-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] out_port
);

  localparam int unsigned ShW = $clog2(DATA_W);

  localparam logic [2:0] OpAdd = 3'd0;
  localparam logic [2:0] OpSub = 3'd1;
  localparam logic [2:0] OpAnd = 3'd2;
  localparam logic [2:0] OpOr  = 3'd3;
  localparam logic [2:0] OpXor = 3'd4;
  localparam logic [2:0] OpShl = 3'd5;
  localparam logic [2:0] OpShr = 3'd6;
  localparam logic [2:0] OpMul = 3'd7;

  typedef enum logic [1:0] {StIdle, StTa, StTb, StTc} state_e;

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [REG_AW-1:0]   ra_q, ra_d, rb_q, rb_d, rd_q, rd_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [DATA_W-1:0]   y_q, y_d, zlo_q, zlo_d, zhi_q, zhi_d, hi_q, hi_d;
  logic                done_q, done_d;

  logic [DATA_W-1:0]   bus;
  logic [DATA_W-1:0]   alu_lo, alu_hi;
  logic [2*DATA_W-1:0] prod;

  always_comb begin
    bus = '0;
    unique case (state_q)
      StIdle: bus = '0;
      StTa:   bus = regs_q[ra_q];
      StTb:   bus = regs_q[rb_q];
      StTc:   bus = zlo_q;
    endcase
  end

  // Operands are sign-extended to full width so the low 2*DATA_W bits are the signed product.
  assign prod = {{DATA_W{y_q[DATA_W-1]}}, y_q} * {{DATA_W{bus[DATA_W-1]}}, bus};

  always_comb begin
    alu_lo = '0;
    alu_hi = '0;
    unique case (op_q)
      OpAdd: alu_lo = y_q + bus;
      OpSub: alu_lo = y_q - bus;
      OpAnd: alu_lo = y_q & bus;
      OpOr:  alu_lo = y_q | bus;
      OpXor: alu_lo = y_q ^ bus;
      OpShl: alu_lo = y_q << bus[ShW-1:0];
      OpShr: alu_lo = y_q >> bus[ShW-1:0];
      OpMul: begin
        alu_lo = prod[DATA_W-1:0];
        alu_hi = prod[2*DATA_W-1:DATA_W];
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rd_d    = rd_q;
    regs_d  = regs_q;
    y_d     = y_q;
    zlo_d   = zlo_q;
    zhi_d   = zhi_q;
    hi_d    = hi_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Host write lands on the same edge as start, so TA already sees it.
        if (wr_en) regs_d[wr_addr] = wr_data;
        if (start) begin
          op_d    = op;
          ra_d    = ra;
          rb_d    = rb;
          rd_d    = rd;
          state_d = StTa;
        end
      end
      StTa: begin
        y_d     = bus;
        state_d = StTb;
      end
      StTb: begin
        zlo_d   = alu_lo;
        zhi_d   = alu_hi;
        state_d = StTc;
      end
      StTc: begin
        regs_d[rd_q] = bus;
        if (op_q == OpMul) hi_d = zhi_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q <= StIdle;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rd_q    <= '0;
      regs_q  <= '{default: '0};
      y_q     <= '0;
      zlo_q   <= '0;
      zhi_q   <= '0;
      hi_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rd_q    <= rd_d;
      regs_q  <= regs_d;
      y_q     <= y_d;
      zlo_q   <= zlo_d;
      zhi_q   <= zhi_d;
      hi_q    <= hi_d;
      done_q  <= done_d;
    end
  end

  assign rd_data  = regs_q[rd_addr];
  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign hi_out   = hi_q;
  assign out_port = regs_q[0];

endmodule

// File: doc/datapath_seq.md
DATAPATH_SEQ -- requirements
Module: datapath_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the width of the bus, registers, Y, Z halves and HI.
REQ-002 SHALL have parameter NUM_REGS, default 16, meaning the general-purpose register count (power of 2, >=2); derived REG_AW = clog2(NUM_REGS).
REQ-003 SHALL have ports:
- clock  in  1  the single clock; all state updates on its rising edge.
- clear  in  1  synchronous, active-low reset, sampled on the rising edge of clock.
- start  in  1  request to run one ALU instruction.
- op  in  3  operation code: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR (logical), 7 MUL (signed).
- ra, rb, rd  in  REG_AW each  operand A, operand B and destination register.
- wr_en  in  1  host write strobe.
- wr_addr  in  REG_AW  host write register address.
- wr_data  in  DATA_W  host write data.
- rd_addr  in  REG_AW  host read address.
- rd_data  out  DATA_W  combinational read of R[rd_addr].
- busy  out  1  instruction in progress.
- done  out  1  one-cycle completion pulse.
- hi_out  out  DATA_W  HI register contents.
- out_port  out  DATA_W  always equals R[0].

Function
REQ-004 SHALL hold a register file R[0..NUM_REGS-1], plus registers Y, Zlow, Zhigh and HI, each DATA_W bits; all are internal state except where exposed by ports.
REQ-005 SHALL implement a sequencer with states IDLE, TA, TB, TC, plus a registered done flag.
REQ-006 In IDLE with start=1, SHALL latch op, ra, rb and rd and move to TA; with start=0, SHALL stay in IDLE.
REQ-007 In TA, SHALL drive the internal bus with R[ra], load Y from the bus, and move to TB.
REQ-008 In TB, SHALL drive the bus with R[rb], load {Zhigh, Zlow} from ALU(Y, bus), and move to TC.
REQ-009 In TC, SHALL drive the bus with Zlow, write R[rd] from the bus, load HI from Zhigh only when op=MUL, set done on that edge, and move to IDLE.
REQ-010 SHALL drive busy=1 exactly in TA, TB and TC.
REQ-011 SHALL drive done=1 for exactly the one cycle following the TC edge, giving start-to-done latency of 4 cycles.
REQ-012 SHALL accept a new start in the cycle done=1, since the state is IDLE then.
REQ-013 SHALL ignore start while busy=1; the latched operands SHALL NOT change.
REQ-014 SHALL write R[wr_addr] from wr_data on wr_en=1 only when in IDLE; wr_en while busy=1 SHALL be ignored with no write.
REQ-015 When start and wr_en are both 1 in IDLE, SHALL perform the write on that edge; TA and TB SHALL see the written value.
REQ-016 ALU arithmetic: ADD and SUB SHALL wrap modulo 2^DATA_W.
REQ-017 ALU logic ops SHALL be bitwise.
REQ-018 SHL and SHR SHALL shift Y by bus[clog2(DATA_W)-1:0], ignoring the upper bits of the shift amount.
REQ-019 For all non-MUL ops, Zhigh SHALL be 0 and HI SHALL be unchanged.
REQ-020 MUL SHALL form the full signed 2*DATA_W-bit two's-complement product: low half to Zlow (and R[rd]), high half to Zhigh (and HI).
REQ-021 rd SHALL be allowed to equal ra or rb; write-back occurs in TC, after both operand reads.
REQ-022 rd=0 SHALL be a legal destination; out_port reflects the new value in the cycle after TC.
REQ-023 rd_data SHALL reflect a write combinationally from the cycle after that write's edge.

Reset
REQ-024 On any rising edge with clear=0, SHALL force state to IDLE and zero all R[], Y, Zlow, Zhigh and HI.
REQ-025 Reset SHALL set busy=0 and done=0; rd_data, hi_out and out_port SHALL read 0.
REQ-026 clear=0 SHALL override start and wr_en on the same edge.
REQ-027 clear=0 mid-operation (TA, TB or TC) SHALL abort the operation with no write-back and no done pulse.

Verification
REQ-028 Host-write R1=0x0000_0005 and R2=0x0000_0003, then start ADD ra=1 rb=2 rd=3 -> busy=1 for 3 cycles; done pulses 4 cycles after start; R3=0x0000_0008; HI unchanged.
REQ-029 R1=0xFFFF_FFFE, R2=0x0000_0003, MUL rd=4 -> R4=0xFFFF_FFFA; hi_out=0xFFFF_FFFF.
REQ-030 R1=0x0000_0000, R2=0x0000_0001, SUB rd=0 -> out_port=0xFFFF_FFFF; R1=0x8000_0001 SHL by R2=0x0000_0021 -> result 0x0000_0002 (shift amount 1).
REQ-031 Apply start and wr_en(R5=7) together in IDLE, op ADD ra=5 rb=5 rd=5 -> R5=14; during busy, wr_en(R6=9) and a second start -> R6 stays 0, exactly one done pulse.
REQ-032 Assert clear=0 during TB of an op with rd=7 -> R7=0, done never pulses, busy=0 next cycle; a new op after clear=1 completes normally.
REQ-033 Issue back-to-back ops with start held high -> the second op begins in the done cycle; throughput is one op per 4 cycles.
